// File: rtl/booth_mul_seq.sv
// Sequential radix-4 Booth signed multiplier: WIDTH/2 iterations per product,
// start/busy/done handshake, product held in z_hi/z_lo until the next completion.
module booth_mul_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z_hi,
    output logic [WIDTH-1:0] z_lo
);

    localparam int unsigned MW    = WIDTH + 2;
    localparam int unsigned PW    = MW + WIDTH + 1;
    localparam int unsigned STEPS = WIDTH / 2;
    localparam int unsigned CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state, state_d;
    logic            busy_d, done_d;
    logic            load, step, finish;
    logic [MW-1:0]   m;
    logic [PW-1:0]   p;
    logic [CW-1:0]   cnt;
    logic [MW-1:0]   m_x2;
    logic [MW-1:0]   term;
    logic [MW-1:0]   sum;
    logic [PW-1:0]   p_next;

    // Next-state and handshake decode
    always_comb begin
        state_d = state;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                    load    = 1'b1;
                end
            end
            S_RUN: begin
                step   = 1'b1;
                busy_d = 1'b1;
                if (cnt == LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    finish  = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Booth recoding of the current triplet and one add-and-shift step
    always_comb begin
        m_x2 = {m[MW-2:0], 1'b0};
        case (p[2:0])
            3'b001, 3'b010: term = m;
            3'b011:         term = m_x2;
            3'b100:         term = ~m_x2 + MW'(1);
            3'b101, 3'b110: term = ~m + MW'(1);
            default:        term = '0;
        endcase
        sum    = p[PW-1 -: MW] + term;
        p_next = PW'($signed({sum, p[WIDTH:0]}) >>> 2);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            m    <= '0;
            p    <= '0;
            cnt  <= '0;
            z_hi <= '0;
            z_lo <= '0;
        end else begin
            if (load) begin
                m   <= {{2{a[WIDTH-1]}}, a};
                p   <= {MW'(0), b, 1'b0};
                cnt <= '0;
            end else if (step) begin
                p   <= p_next;
                cnt <= cnt + CW'(1);
            end
            if (finish) begin
                {z_hi, z_lo} <= p_next[2*WIDTH:1];
            end
        end
    end

endmodule
